// File: rtl/clock_divide_if.sv
`default_nettype none
// ============================================================================
// Module   : clock_divide_if
// Brief    : Control/status bundle between a requester and the clock divider.
// Revision : 1.0 - initial release
// ============================================================================
interface clock_divide_if #(
    parameter int DIV_WIDTH = 8
);
    logic                 enable;
    logic [DIV_WIDTH-1:0] divide_value;
    logic                 divide_load;
    logic                 divide_ack;
    logic                 divide_error;
    logic                 divided_freq;
    logic                 divided_tick;
    logic                 busy;

    modport master (
        output enable, divide_value, divide_load,
        input  divide_ack, divide_error, divided_freq, divided_tick, busy
    );

    modport slave (
        input  enable, divide_value, divide_load,
        output divide_ack, divide_error, divided_freq, divided_tick, busy
    );
endinterface
`default_nettype wire

// File: rtl/clock_divide.sv
`default_nettype none
// ============================================================================
// Module   : clock_divide
// Brief    : Programmable integer clock divider with registered divided clock,
//            period-start tick and boundary-aligned runtime divisor reload.
// Revision : 1.0 - initial release
// ============================================================================
module clock_divide #(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  wire logic        base_clock,
    input  wire logic        reset_n,
    clock_divide_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    localparam logic [DIV_WIDTH-1:0] c_default_div = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] c_min_div     = DIV_WIDTH'(2);

    state_t               r_state;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_active_div;
    logic [DIV_WIDTH-1:0] r_pending_div;
    logic                 r_pending;
    logic                 r_freq;
    logic                 r_tick;
    logic                 r_ack;
    logic                 r_err;
    logic                 r_busy;

    logic                 w_wrap;
    logic [DIV_WIDTH-1:0] w_cnt_next;
    logic [DIV_WIDTH:0]   w_high_len;
    logic                 w_load_ok;
    logic                 w_load_bad;

    assign w_wrap     = (r_cnt == (r_active_div - 1'b1));
    assign w_cnt_next = w_wrap ? '0 : (r_cnt + 1'b1);
    // A wrap always lands on cnt 0, which is high for any divisor, so the
    // current divisor's high length is correct even when a reload applies.
    assign w_high_len = ({1'b0, r_active_div} + 1'b1) >> 1;
    assign w_load_ok  = bus.divide_load && (bus.divide_value >= c_min_div);
    assign w_load_bad = bus.divide_load && (bus.divide_value <  c_min_div);

    always_ff @(posedge base_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_active_div  <= c_default_div;
            r_pending_div <= '0;
            r_pending     <= 1'b0;
            r_freq        <= 1'b0;
            r_tick        <= 1'b0;
            r_ack         <= 1'b0;
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_ack <= w_load_ok;
            r_err <= w_load_bad;

            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        r_active_div <= r_pending_div;
                        r_pending    <= 1'b0;
                    end
                    r_cnt <= '0;
                    if (bus.enable) begin
                        r_state <= S_RUN;
                        r_freq  <= 1'b1;
                        r_tick  <= 1'b1;
                        r_busy  <= 1'b1;
                    end else begin
                        r_freq  <= 1'b0;
                        r_tick  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end

                S_RUN, S_STOP: begin
                    if (w_wrap && r_pending) begin
                        r_active_div <= r_pending_div;
                        r_pending    <= 1'b0;
                    end
                    // Enable low at the period end: never start a new period.
                    if (w_wrap && !bus.enable) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_freq  <= 1'b0;
                        r_tick  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= bus.enable ? S_RUN : S_STOP;
                        r_cnt   <= w_cnt_next;
                        r_freq  <= ({1'b0, w_cnt_next} < w_high_len);
                        r_tick  <= w_wrap;
                        r_busy  <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_freq  <= 1'b0;
                    r_tick  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase

            // Placed last so a load on a wrap edge stays pending for the next wrap.
            if (w_load_ok) begin
                r_pending_div <= bus.divide_value;
                r_pending     <= 1'b1;
            end
        end
    end

    assign bus.divide_ack   = r_ack;
    assign bus.divide_error = r_err;
    assign bus.divided_freq = r_freq;
    assign bus.divided_tick = r_tick;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire
